lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store unit between the core's execute stage and the data memory (single-port RAM with req/gnt/rvalid protocol).
- Takes one load or store request at a time and produces the word-aligned address and byte enables.
- Aligns store data into byte lanes, and extracts and sign- or zero-extends load data.
- Holds the core stalled until the memory transaction completes, and flags misaligned accesses without issuing them.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  core presents a load/store this cycle
- req_ready_o  out  1  unit accepts the request (handshake = req_valid_i & req_ready_o)
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  ADDR_W  byte address (already computed rs1+imm)
- wdata_i  in  DATA_W  store data (rs2), value in the low bits
- rd_data_o  out  DATA_W  extended load result
- rd_valid_o  out  1  one-cycle pulse: load result valid, or store complete
- misalign_o  out  1  one-cycle pulse: request rejected as misaligned/illegal
- stall_o  out  1  core must hold the pipeline
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory accepted the request
- data_rvalid_i  in  1  memory response valid (loads and stores)
- data_addr_o  out  ADDR_W  word address: {addr[31:2],2'b00}
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  DATA_W  lane-aligned store data
- data_rdata_i  in  DATA_W  raw read word

Behaviour:
- Reset (rst=1 at the clock edge):
  - State goes to IDLE.
  - All outputs are 0 except req_ready_o=1.
  - Any in-flight transaction is abandoned; a late data_rvalid_i after reset is ignored while in IDLE.
- FSM state IDLE:
  - req_ready_o=1, stall_o=0.
  - On handshake:
    - Legality check: misaligned when (H/HU and addr[0]) or (W and addr[1:0]!=0); illegal when funct3 is 011, 110 or 111.
    - Misaligned or illegal: misalign_o pulses the next cycle, no memory access, stay in IDLE.
    - Otherwise latch addr[1:0], funct3 and we, then go to REQ.
- FSM state REQ:
  - data_req_o=1, stall_o=1, req_ready_o=0.
  - Address, be, we and wdata stay stable until the cycle in which data_gnt_i=1.
  - On data_gnt_i=1, go to RESP.
- FSM state RESP:
  - data_req_o=0, stall_o=1.
  - On data_rvalid_i=1:
    - rd_valid_o=1 in the same cycle (combinational from rvalid).
    - For loads, rd_data_o is driven from data_rdata_i.
    - Go to IDLE.
  - rd_data_o holds its last value afterwards (registered copy).
- Minimum latency: handshake in cycle 0, data_req_o in cycle 1. With gnt in cycle 1 and rvalid in cycle 2, rd_valid_o is in cycle 2 and the next request is accepted in cycle 3.
- Byte enables, by offset off = addr[1:0]:
  - B/BU: 4'b0001<<off
  - H/HU: 4'b0011<<off
  - W: 4'b1111
- Store data:
  - B: replicate byte {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: as is
- Load extraction:
  - B/BU: byte at lane off, sign- or zero-extended.
  - H/HU: halfword at lane off[1], sign- or zero-extended.
  - W: the whole word.
  - Stores produce rd_valid_o but rd_data_o is unchanged.
- Boundary conditions:
  - data_gnt_i and data_rvalid_i both high in REQ: treat as gnt only. rvalid is only honoured in RESP.
  - req_valid_i while busy: ignored (req_ready_o=0); the core holds it because stall_o=1.
  - Exactly one transaction outstanding at any time.

Test Plan:
- Load widths: mem[0x0]=0x8899AABB. LW@0x0 -> rd_data_o=0x8899AABB, be=1111. LB@0x1 -> 0xFFFFFFAA. LBU@0x1 -> 0x000000AA. LH@0x2 -> 0xFFFF8899. LHU@0x2 -> 0x00008899.
- Store widths, starting from mem[0x4]=0x00000000:
  - SB wdata=0x12345678@0x5 -> be=0010, data_wdata_o=0x78787878, mem[0x4]=0x00007800.
  - SH wdata=0xCAFE@0x6 -> be=1100, mem[0x4]=0xCAFE7800.
  - SW 0xDEADBEEF@0x4 -> mem[0x4]=0xDEADBEEF; read back with LW.
- Store with stall: hold data_gnt_i=0 for 3 cycles -> data_req_o, address, be and data stay stable; stall_o=1 throughout; rd_valid_o=1 exactly once, after rvalid.
- Misalign: LW@0x2 and SH@0x3 -> misalign_o pulses once each; data_req_o stays 0; next LW@0x0 completes normally.
- Reset mid-operation: rst=1 in RESP before rvalid -> next cycle state IDLE, stall_o=0, req_ready_o=1; the following rvalid pulse produces no rd_valid_o.
- Back-to-back: SW 0x11223344@0x8 immediately followed by LW@0x8 with zero-wait memory -> LW returns 0x11223344; rd_valid_o pulses in cycles 2 and 5.

Source files
------------

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - load/store unit bridging execute stage to a req/gnt/rvalid data memory
module lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              misalign_o,
    output logic              stall_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic [DATA_W-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              misalign_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              handshake;
    logic              bad_d;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic              resp_done;

    assign handshake = req_valid_i && (state_q == S_IDLE);
    assign resp_done = (state_q == S_RESP) && data_rvalid_i;

    // Request decode: legality, lane enables and lane-replicated store data
    always_comb begin
        bad_d   = 1'b0;
        be_d    = 4'b0000;
        wdata_d = wdata_i;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                bad_d   = addr_i[0];
                be_d    = 4'b0011 << addr_i[1:0];
                wdata_d = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                bad_d   = (addr_i[1:0] != 2'b00);
                be_d    = 4'b1111;
            end
            default: bad_d = 1'b1;
        endcase
    end

    // Load extraction from the raw word using the latched offset and width
    always_comb begin
        byte_sel = data_rdata_i[7:0];
        case (off_q)
            2'd0: byte_sel = data_rdata_i[7:0];
            2'd1: byte_sel = data_rdata_i[15:8];
            2'd2: byte_sel = data_rdata_i[23:16];
            2'd3: byte_sel = data_rdata_i[31:24];
            default: byte_sel = data_rdata_i[7:0];
        endcase
        half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (funct3_q)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = data_rdata_i;
        endcase
    end

    // Transaction FSM and all registered bus/status state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            misalign_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        if (bad_d) begin
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q   <= {addr_i[ADDR_W-1:2], 2'b00};
                            be_q     <= be_d;
                            wdata_q  <= wdata_d;
                            we_q     <= we_i;
                            funct3_q <= funct3_i;
                            off_q    <= addr_i[1:0];
                            state_q  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // An rvalid coinciding with the grant is not a response to us yet
                    if (data_gnt_i) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (data_rvalid_i) begin
                        if (!we_q) begin
                            rd_data_q <= load_data;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign stall_o      = (state_q != S_IDLE);
    assign data_req_o   = (state_q == S_REQ);
    assign data_addr_o  = addr_q;
    assign data_be_o    = be_q;
    assign data_we_o    = we_q;
    assign data_wdata_o = wdata_q;
    assign misalign_o   = misalign_q;
    assign rd_valid_o   = resp_done;
    // Load result is visible in the rvalid cycle; the register keeps it afterwards
    assign rd_data_o    = (resp_done && !we_q) ? load_data : rd_data_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - self-checking bench for lsu_mem_if
module tb_lsu_mem_if;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        misalign_o;
    logic        stall_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .misalign_o    (misalign_o),
        .stall_o       (stall_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gwait;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          hs_cyc   = 0;
    logic [31:0] mem [16];
    logic [31:0] sb_q [$];
    int          rv_cyc [$];
    logic [31:0] model_rd = 32'h0;
    vec_t        vecs [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every rd_valid pulse consumes one expected rd_data value
    always begin
        @(negedge clk);
        #2;
        if (rd_valid_o) begin
            rv_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rd_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                check("rd_data", rd_data_o, sb_q.pop_front());
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gwait, input logic mis,
                                input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.gwait = gwait;
        v.mis = mis; v.be = be; v.wd = wd; v.rd = rd;
        return v;
    endfunction

    // Drives one request and plays the memory; ends with rvalid raised in the response cycle
    task automatic do_op(input vec_t v);
        logic [31:0] exp;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_gnt_i    = 1'b0;
        check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        check("rd_data_hold", rd_data_o, model_rd);
        hs_cyc      = cyc;
        req_valid_i = 1'b1;
        we_i        = v.we;
        funct3_i    = v.f3;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        if (!v.mis) begin
            exp = v.we ? model_rd : v.rd;
            sb_q.push_back(exp);
            model_rd = exp;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        addr_i      = ~v.addr;
        wdata_i     = ~v.wdata;
        if (v.mis) begin
            check("misalign_pulse", {31'd0, misalign_o}, 32'd1);
            check("mis_no_req", {31'd0, data_req_o}, 32'd0);
            @(negedge clk);
            check("misalign_drop", {31'd0, misalign_o}, 32'd0);
            check("mis_no_req2", {31'd0, data_req_o}, 32'd0);
            return;
        end
        check("misalign_quiet", {31'd0, misalign_o}, 32'd0);
        check("ready_busy", {31'd0, req_ready_o}, 32'd0);
        for (int i = 0; i <= v.gwait; i++) begin
            check("data_req", {31'd0, data_req_o}, 32'd1);
            check("stall_req", {31'd0, stall_o}, 32'd1);
            check("data_addr", data_addr_o, {v.addr[31:2], 2'b00});
            check("data_be", {28'd0, data_be_o}, {28'd0, v.be});
            check("data_we", {31'd0, data_we_o}, {31'd0, v.we});
            if (v.we) check("data_wdata", data_wdata_o, v.wd);
            if (i < v.gwait) @(negedge clk);
        end
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hDEAD0000;
        #1;
        check("rvalid_in_req_ignored", {31'd0, rd_valid_o}, 32'd0);
        if (data_we_o) begin
            for (int b = 0; b < 4; b++)
                if (data_be_o[b]) mem[data_addr_o[5:2]][b*8 +: 8] = data_wdata_o[b*8 +: 8];
        end
        @(negedge clk);
        data_gnt_i = 1'b0;
        check("resp_no_req", {31'd0, data_req_o}, 32'd0);
        check("resp_stall", {31'd0, stall_o}, 32'd1);
        data_rdata_i  = mem[data_addr_o[5:2]];
        data_rvalid_i = 1'b1;
        #1;
        check("rd_valid", {31'd0, rd_valid_o}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
        wdata_i = 32'h0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899AABB;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_req", {31'd0, data_req_o}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_be", {28'd0, data_be_o}, 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_we", {31'd0, data_we_o}, 32'd0);
        rst = 1'b0;

        //             we    f3      addr   wdata         gw mis be       wd            rd
        vecs.push_back(mk(1'b0, 3'b010, 32'h0, 32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'h8899AABB));
        vecs.push_back(mk(1'b0, 3'b000, 32'h1, 32'h0,        1, 1'b0, 4'b0010, 32'h0,        32'hFFFFFFAA));
        vecs.push_back(mk(1'b0, 3'b100, 32'h1, 32'h0,        0, 1'b0, 4'b0010, 32'h0,        32'h000000AA));
        vecs.push_back(mk(1'b0, 3'b001, 32'h2, 32'h0,        0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8899));
        vecs.push_back(mk(1'b0, 3'b101, 32'h2, 32'h0,        2, 1'b0, 4'b1100, 32'h0,        32'h00008899));
        vecs.push_back(mk(1'b0, 3'b000, 32'h3, 32'h0,        0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF88));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0, 32'h0,        0, 1'b0, 4'b0011, 32'h0,        32'h0000AABB));
        vecs.push_back(mk(1'b1, 3'b000, 32'h5, 32'h12345678, 0, 1'b0, 4'b0010, 32'h78787878, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h4, 32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'h00007800));
        vecs.push_back(mk(1'b1, 3'b001, 32'h6, 32'h0000CAFE, 0, 1'b0, 4'b1100, 32'hCAFECAFE, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h4, 32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'hCAFE7800));
        vecs.push_back(mk(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h4, 32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 3'b010, 32'h2, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h3, 32'hFFFF,     0, 1'b1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 3'b110, 32'h0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0, 32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'h8899AABB));

        foreach (vecs[k]) do_op(vecs[k]);

        // Stalled store: grant withheld three cycles, exactly one completion
        @(negedge clk);
        data_rvalid_i = 1'b0;
        rv_cyc.delete();
        do_op(mk(1'b1, 3'b010, 32'hC, 32'h55AA33CC, 3, 1'b0, 4'b1111, 32'h55AA33CC, 32'h0));
        @(negedge clk);
        data_rvalid_i = 1'b0;
        #3;
        check("stall_store_one_rv", rv_cyc.size(), 32'd1);
        check("stall_store_mem", mem[3], 32'h55AA33CC);

        // Back-to-back store then load with zero-wait memory
        rv_cyc.delete();
        do_op(mk(1'b1, 3'b010, 32'h8, 32'h11223344, 0, 1'b0, 4'b1111, 32'h11223344, 32'h0));
        begin
            int c0;
            c0 = hs_cyc;
            do_op(mk(1'b0, 3'b010, 32'h8, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h11223344));
            check("b2b_load_hs_cycle", hs_cyc - c0, 32'd3);
            @(negedge clk);
            data_rvalid_i = 1'b0;
            #3;
            check("b2b_rv_count", rv_cyc.size(), 32'd2);
            if (rv_cyc.size() == 2) begin
                check("b2b_rv0_cycle", rv_cyc[0] - c0, 32'd2);
                check("b2b_rv1_cycle", rv_cyc[1] - c0, 32'd5);
            end
        end

        // Reset while waiting for the response; the late rvalid must be ignored
        @(negedge clk);
        req_valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0;
        @(negedge clk);
        req_valid_i = 1'b0;
        data_gnt_i  = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        check("rstmid_in_resp", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rd = 32'h0;
        check("rstmid_stall", {31'd0, stall_o}, 32'd0);
        check("rstmid_ready", {31'd0, req_ready_o}, 32'd1);
        check("rstmid_req", {31'd0, data_req_o}, 32'd0);
        check("rstmid_rd_data", rd_data_o, 32'h0);
        data_rdata_i  = 32'hBAD0BAD0;
        data_rvalid_i = 1'b1;
        #1;
        check("rstmid_late_rvalid", {31'd0, rd_valid_o}, 32'd0);
        @(negedge clk);
        data_rvalid_i = 1'b0;

        // Normal operation after the reset
        do_op(mk(1'b0, 3'b010, 32'h0, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h8899AABB));
        @(negedge clk);
        data_rvalid_i = 1'b0;
        #3;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
